// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer and its lane aligner.
//   size_e  : access size encoding as it arrives on the request port
//   state_e : sequencer FSM states
//   req_t   : request fields captured at accept time
package mem_pkg;

  localparam int DEPTH_DEF = 512;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_GAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_ERR  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  // Only the low half of store data is kept: word stores drive the memory
  // write data directly at accept, sub-word stores need at most 16 bits.
  typedef struct packed {
    logic        write;
    size_e       size;
    logic        sgn;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte/halfword lane handling for a 32-bit little-endian word.
//   rdata_i : word read from memory
//   lane_i  : byte address bits [1:0]
//   size_i  : access size
//   sgn_i   : sign-extend sub-word loads
//   wdata_i : right-justified store data (byte uses [7:0])
//   ld_o    : extracted and extended load result
//   st_o    : rdata_i with the addressed lanes replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        sgn_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    ld_o = rdata_i;
    st_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
        st_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ld_o = {{16{sgn_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) st_o[31:16] = wdata_i;
        else           st_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only data memory.
// Sub-word stores are done as read-modify-write with a quiet GAP cycle so
// that every memory strobe is a single-cycle pulse with low cycles around it.
//   clk, rst_n                  : clock, async active-low reset
//   reqValid/reqReady           : request handshake (accepted only in IDLE)
//   reqWrite/Size/Signed/Addr/Data : request fields, sampled at accept
//   respValid/respData/respErr  : one-cycle completion pulse and result
//   busy                        : stall request, high outside IDLE
//   memAddr/memDataIn/memRead/memWrite/memDataOut : data memory port
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WORD_AW = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic        busy,
  output logic [31:0] memAddr,
  output logic [31:0] memDataIn,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memDataOut
);

  state_e             state_q;
  req_t               req_q;
  logic [WORD_AW-1:0] waddr_q;
  logic [31:0]        wdata_q, rdata_q;
  logic               rd_q, wr_q, rvld_q, rerr_q;

  size_e       sz;
  logic        misal, oor, bad;
  logic [31:0] ld_word, st_word;

  assign sz    = size_e'(reqSize);
  assign misal = (sz == SZ_HALF && reqAddr[0]) ||
                 (sz == SZ_WORD && reqAddr[1:0] != 2'b00);
  assign oor   = {2'b00, reqAddr[31:2]} >= 32'(DEPTH);
  assign bad   = misal || oor || (sz == SZ_ILL);

  mem_lane_align u_align (
    .rdata_i (memDataOut),
    .lane_i  (req_q.lane),
    .size_i  (req_q.size),
    .sgn_i   (req_q.sgn),
    .wdata_i (req_q.wdata),
    .ld_o    (ld_word),
    .st_o    (st_word)
  );

  // Strobes and response are registered alongside the state so each is a
  // clean single-cycle pulse aligned with RD / WR / DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rvld_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (reqValid) begin
          req_q  <= '{write: reqWrite, size: sz, sgn: reqSigned,
                      lane: reqAddr[1:0], wdata: reqData[15:0]};
          rerr_q <= 1'b0;
          if (bad) begin
            state_q <= ST_ERR;
          end else begin
            waddr_q <= reqAddr[2 +: WORD_AW];
            if (reqWrite && sz == SZ_WORD) begin
              wdata_q <= reqData;
              wr_q    <= 1'b1;
              state_q <= ST_WR;
            end else begin
              rd_q    <= 1'b1;
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: state_q <= ST_CAP;
        ST_CAP: begin
          if (req_q.write) begin
            wdata_q <= st_word;
            state_q <= ST_GAP;
          end else begin
            rdata_q <= ld_word;
            rvld_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_GAP: begin
          wr_q    <= 1'b1;
          state_q <= ST_WR;
        end
        ST_WR: begin
          rdata_q <= '0;
          rvld_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_ERR: begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
          rvld_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while reset is held.
  assign reqReady  = rst_n && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign respValid = rvld_q;
  assign respData  = rdata_q;
  assign respErr   = rerr_q;
  assign memAddr   = {{(32-WORD_AW){1'b0}}, waddr_q};
  assign memDataIn = wdata_q;
  assign memRead   = rd_q;
  assign memWrite  = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [31:0] reqAddr = '0, reqData = '0;
  logic        reqReady, respValid, respErr, busy, memRead, memWrite;
  logic [31:0] respData, memAddr, memDataIn;
  logic [31:0] memDataOut = '0;

  logic [31:0] mem [0:511];
  int nvec = 0, nmis = 0;
  int rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic [31:0] last_wr_addr = '0;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(512), .WORD_AW(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respErr(respErr), .busy(busy),
    .memAddr(memAddr), .memDataIn(memDataIn), .memRead(memRead),
    .memWrite(memWrite), .memDataOut(memDataOut)
  );

  // Word memory: one-cycle read latency, write on strobe.
  always @(posedge clk) begin
    if (memWrite) mem[memAddr[8:0]] <= memDataIn;
    if (memRead)  memDataOut <= mem[memAddr[8:0]];
  end

  // Strobe discipline and busy/ready consistency, observed every cycle.
  always @(negedge clk) begin
    if (memRead)  rd_cnt++;
    if (memWrite) begin wr_cnt++; last_wr_addr = memAddr; end
    if (memRead && memWrite) viol++;
    if ((memRead || memWrite) && prev_strobe) viol++;
    if ((memRead || memWrite) && memAddr[31:9] != 0) viol++;
    if (rst_n && (busy == reqReady)) viol++;
    prev_strobe = memRead || memWrite;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE; returns result and latency in cycles
  // (1 = first cycle after the accept edge).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
    reqAddr = addr; reqData = data;
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = respData;
    err = respErr;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, r0, w0;
  int          pulses, first_at, gap_at;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Reset state
    #12;
    chk("rst_ready", {31'b0, reqReady}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_strobes", {30'b0, memRead, memWrite}, 0);
    chk("rst_resp", {30'b0, respValid, respErr}, 0);
    chk("rst_rdata", respData, 0);
    chk("rst_maddr", memAddr, 0);
    chk("rst_mdin", memDataIn, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, reqReady}, 1);

    // Word store then word load
    w0 = wr_cnt;
    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, d, e, lat);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'b0, e}, 0);
    chk("sw_wr_pulses", wr_cnt - w0, 1);
    chk("sw_wr_addr", last_wr_addr, 4);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    do_req(0, 2'b10, 0, 32'h10, 0, d, e, lat);
    chk("lw_lat", lat, 3);
    chk("lw_data", d, 32'hDEADBEEF);

    // Sub-word loads
    @(negedge clk); mem[4] = 32'h11223344;
    do_req(0, 2'b00, 1, 32'h13, 0, d, e, lat);
    chk("lb_13", d, 32'h00000011);
    do_req(0, 2'b00, 0, 32'h10, 0, d, e, lat);
    chk("lbu_10", d, 32'h00000044);
    @(negedge clk); mem[4] = 32'h8000FFFF;
    do_req(0, 2'b01, 1, 32'h12, 0, d, e, lat);
    chk("lh_12", d, 32'hFFFF8000);
    do_req(0, 2'b01, 0, 32'h12, 0, d, e, lat);
    chk("lhu_12", d, 32'h00008000);
    do_req(0, 2'b00, 1, 32'h11, 0, d, e, lat);
    chk("lb_11_neg", d, 32'hFFFFFFFF);
    do_req(0, 2'b10, 1, 32'h10, 0, d, e, lat);
    chk("lw_ignores_sgn", d, 32'h8000FFFF);

    // Sub-word stores (read-modify-write)
    @(negedge clk); mem[4] = 32'hAABBCCDD;
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1, 2'b00, 0, 32'h11, 32'hFFFFFF5A, d, e, lat);
    chk("sb_lat", lat, 5);
    chk("sb_rd_pulses", rd_cnt - r0, 1);
    chk("sb_wr_pulses", wr_cnt - w0, 1);
    chk("sb_mem", mem[4], 32'hAABB5ADD);
    do_req(1, 2'b01, 0, 32'h12, 32'h00001234, d, e, lat);
    chk("sh_mem", mem[4], 32'h12345ADD);

    // Top word of memory is in range
    do_req(1, 2'b10, 0, 32'h7FC, 32'h0BADF00D, d, e, lat);
    chk("sw_last_err", {31'b0, e}, 0);
    chk("sw_last_mem", mem[511], 32'h0BADF00D);

    // Error cases: no strobes, respErr with zero data
    r0 = rd_cnt; w0 = wr_cnt;
    do_req(0, 2'b10, 0, 32'h02, 0, d, e, lat);
    chk("lw_mis_err", {31'b0, e}, 1);
    chk("lw_mis_lat", lat, 2);
    chk("lw_mis_data", d, 0);
    do_req(0, 2'b01, 0, 32'h01, 0, d, e, lat);
    chk("lh_mis_err", {31'b0, e}, 1);
    do_req(1, 2'b11, 0, 32'h10, 32'h1, d, e, lat);
    chk("size11_err", {31'b0, e}, 1);
    do_req(1, 2'b10, 0, 32'h800, 32'h1, d, e, lat);
    chk("oor_err", {31'b0, e}, 1);
    chk("oor_data", d, 0);
    chk("err_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    chk("mem4_after_err", mem[4], 32'h12345ADD);

    // Reset during CAP of a halfword store
    @(negedge clk); mem[4] = 32'hCAFEF00D;
    w0 = wr_cnt;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b01; reqAddr = 32'h10; reqData = 32'h0000BEEF;
    @(negedge clk); reqValid = 1'b0;   // RD
    @(negedge clk);                    // CAP
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_ready", {31'b0, reqReady}, 0);
    chk("midrst_strobes", {30'b0, memRead, memWrite}, 0);
    chk("midrst_mdin", memDataIn, 0);
    chk("midrst_maddr", memAddr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", wr_cnt - w0, 0);
    chk("midrst_mem", mem[4], 32'hCAFEF00D);
    chk("midrst_ready_back", {31'b0, reqReady}, 1);

    // reqValid held high: loads re-accepted only in IDLE after DONE
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqAddr = 32'h10;
    pulses = 0; first_at = 0; gap_at = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (respValid) begin
        pulses++;
        if (first_at == 0) first_at = i;
        else if (gap_at == 0) gap_at = i - first_at;
      end
    end
    reqValid = 1'b0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_first", first_at, 3);
    chk("b2b_period", gap_at, 4);
    lat = 0;
    while (busy && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_drain_idle", {31'b0, busy}, 0);

    chk("strobe_discipline", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
